// File: rtl/bloom_filter_query_if.sv
// Query/result handshake and BRAM read port of the Bloom filter query block.
// master = key source / result sink / BRAM model, slave = bloom_filter_query.
interface bloom_filter_query_if #(
    parameter int DATA_W = 72,
    parameter int ADDR_W = 11,
    parameter int ROW_W  = 2048
);
    logic              query_valid;
    logic              query_ready;
    logic [DATA_W-1:0] query_data;
    logic              result_valid;
    logic              result_ready;
    logic              result_hit;
    logic              busy;
    logic              ena;
    logic              wea;
    logic [ADDR_W-1:0] addra;
    logic [ROW_W-1:0]  douta;

    modport master (
        output query_valid, query_data, result_ready, douta,
        input  query_ready, result_valid, result_hit, busy, ena, wea, addra
    );

    modport slave (
        input  query_valid, query_data, result_ready, douta,
        output query_ready, result_valid, result_hit, busy, ena, wea, addra
    );
endinterface

// File: rtl/bloom_filter_query.sv
// Bloom filter membership test: hashes a key with NUM_HASH Jenkins seeds and reads each row.
// Optional macro BLOOM_QUERY_EARLY_EXIT_EN stops issuing reads at the first observed miss.
module bloom_hash_lane #(
    parameter int          DATA_W = 72,
    parameter int          ADDR_W = 11,
    parameter logic [31:0] SEED   = 32'hdeadbeef
) (
    input  logic [DATA_W-1:0] key_i,
    output logic [ADDR_W-1:0] addr_o
);
    always_comb begin
        logic [31:0] h;
        h = SEED;
        for (int i = 0; i < DATA_W / 8; i++) begin
            h = h + 32'(key_i[i*8 +: 8]);
            h = h + (h << 10);
            h = h ^ (h >> 6);
        end
        h = h + (h << 3);
        h = h ^ (h >> 11);
        h = h + (h << 15);
        addr_o = h[ADDR_W-1:0];
    end
endmodule

module bloom_filter_query #(
    parameter int DATA_W       = 72,
    parameter int ADDR_W       = 11,
    parameter int ROW_W        = 2048,
    parameter int NUM_HASH     = 7,
    parameter int READ_LATENCY = 1
) (
    input logic                  clka,
    input logic                  rst,
    bloom_filter_query_if.slave  bus
);
    localparam logic [6:0][31:0] SEEDS = {
        32'hba5eba11, 32'hfeedface, 32'h0badc0de, 32'habcdef01,
        32'h12345678, 32'hcafebabe, 32'hdeadbeef
    };

    typedef enum logic [2:0] {IDLE, HASH, ISSUE, DRAIN, RESP} state_t;

    state_t                           state_q, state_d;
    logic [DATA_W-1:0]                key_q;
    logic [NUM_HASH-1:0][ADDR_W-1:0]  hash_w;
    logic [NUM_HASH-1:0][ADDR_W-1:0]  addr_q;
    logic [2:0]                       cnt_q;
    logic                             miss_q;
    logic                             ena_q;
    logic [ADDR_W-1:0]                addra_q;
    logic [READ_LATENCY:1]            tag_q;
    logic                             due, row_miss, pend, last_issue, stop_issue;

    for (genvar k = 0; k < NUM_HASH; k++) begin : g_lane
        bloom_hash_lane #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W),
            .SEED   (SEEDS[k])
        ) u_lane (
            .key_i  (key_q),
            .addr_o (hash_w[k])
        );
    end

    // tag_q[i] marks a read issued i cycles ago; the top bit is the one whose data is on douta now
    assign due        = tag_q[READ_LATENCY];
    assign row_miss   = due && !(|bus.douta);
    assign last_issue = (cnt_q == 3'(NUM_HASH - 1));

`ifdef BLOOM_QUERY_EARLY_EXIT_EN
    assign stop_issue = last_issue || row_miss;
`else
    assign stop_issue = last_issue;
`endif

    always_comb begin
        pend = 1'b0;
        for (int i = 1; i < READ_LATENCY; i++) pend = pend | tag_q[i];
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.query_valid) state_d = HASH;
            HASH:    state_d = ISSUE;
            ISSUE:   if (stop_issue) state_d = DRAIN;
            DRAIN:   if (!pend) state_d = RESP;
            RESP:    if (bus.result_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clka) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clka) begin
        if (rst) begin
            key_q   <= '0;
            addr_q  <= '0;
            cnt_q   <= '0;
            miss_q  <= 1'b0;
            ena_q   <= 1'b0;
            addra_q <= '0;
            tag_q   <= '0;
        end else begin
            tag_q[1] <= ena_q;
            for (int i = 2; i <= READ_LATENCY; i++) tag_q[i] <= tag_q[i-1];
            if (row_miss) miss_q <= 1'b1;
            unique case (state_q)
                IDLE: if (bus.query_valid) key_q <= bus.query_data;
                HASH: begin
                    addr_q  <= hash_w;
                    addra_q <= hash_w[0];
                    ena_q   <= 1'b1;
                    cnt_q   <= '0;
                    miss_q  <= 1'b0;
                end
                ISSUE: begin
                    if (stop_issue) begin
                        ena_q <= 1'b0;
                    end else begin
                        cnt_q   <= cnt_q + 3'd1;
                        addra_q <= addr_q[cnt_q + 3'd1];
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.query_ready  = (state_q == IDLE) && !rst;
    assign bus.result_valid = (state_q == RESP);
    assign bus.result_hit   = (state_q == RESP) && !miss_q;
    assign bus.busy         = (state_q != IDLE);
    assign bus.ena          = ena_q;
    assign bus.addra        = addra_q;
    assign bus.wea          = 1'b0;
endmodule

// File: tb/tb_bloom_filter_query.sv
// Bench for bloom_filter_query: READ_LATENCY=1 and READ_LATENCY=3 instances against a sparse BRAM model.
// Honours BLOOM_QUERY_EARLY_EXIT_EN the same way as the design.
module tb_bloom_filter_query;
    localparam int DATA_W = 72;
    localparam int ADDR_W = 11;
    localparam int ROW_W  = 2048;
    localparam int NH     = 7;
    localparam int RL_A   = 1;
    localparam int RL_B   = 3;
    localparam logic [31:0] SEED [NH] = '{32'hdeadbeef, 32'hcafebabe, 32'h12345678,
        32'habcdef01, 32'h0badc0de, 32'hfeedface, 32'hba5eba11};

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bloom_filter_query_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ROW_W(ROW_W)) ifa ();
    bloom_filter_query_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ROW_W(ROW_W)) ifb ();

    bloom_filter_query #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ROW_W(ROW_W),
        .NUM_HASH(NH), .READ_LATENCY(RL_A)) dut_a (.clka(clk), .rst(rst), .bus(ifa));
    bloom_filter_query #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ROW_W(ROW_W),
        .NUM_HASH(NH), .READ_LATENCY(RL_B)) dut_b (.clka(clk), .rst(rst), .bus(ifb));

    int checks = 0;
    int errors = 0;

    // mem_bit[a] < 0: row a is all zero; otherwise only bit mem_bit[a] is set
    int mem_bit [1 << ADDR_W];
    logic [ADDR_W-1:0] q_a[$];
    logic [ADDR_W-1:0] q_b[$];
    int wea_bad = 0;
    logic              eb1, eb2;
    logic [ADDR_W-1:0] ab1, ab2;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [ADDR_W-1:0] ref_addr(input logic [DATA_W-1:0] key, input int k);
        logic [31:0] h;
        h = SEED[k];
        for (int i = 0; i < DATA_W / 8; i++) begin
            h += 32'(key[8*i +: 8]);
            h += h << 10;
            h ^= h >> 6;
        end
        h += h << 3;
        h ^= h >> 11;
        h += h << 15;
        return h[ADDR_W-1:0];
    endfunction

    function automatic logic [ROW_W-1:0] row_of(input int b);
        logic [ROW_W-1:0] r;
        r = '0;
        if (b >= 0) r[b] = 1'b1;
        return r;
    endfunction

    // Junk on douta whenever no read is due; always nonzero so a stray sample cannot fake a miss
    function automatic logic [ROW_W-1:0] junk();
        logic [ROW_W-1:0] g;
        for (int i = 0; i < ROW_W / 32; i++) g[i*32 +: 32] = $urandom;
        g[ROW_W-1] = 1'b1;
        return g;
    endfunction

    always @(posedge clk) begin
        ifa.douta <= ifa.ena ? row_of(mem_bit[ifa.addra]) : junk();
        eb1 <= ifb.ena;
        ab1 <= ifb.addra;
        eb2 <= eb1;
        ab2 <= ab1;
        ifb.douta <= eb2 ? row_of(mem_bit[ab2]) : junk();
    end

    always @(negedge clk) begin
        if (ifa.ena === 1'b1) q_a.push_back(ifa.addra);
        if (ifb.ena === 1'b1) q_b.push_back(ifb.addra);
        if (ifa.wea !== 1'b0 || ifb.wea !== 1'b0) wea_bad++;
    end

    // mode 0: all-zero BRAM; 1: key rows set; 2: key rows randomly set/cleared over noise rows
    task automatic preload(input logic [DATA_W-1:0] key, input int mode, input int clr);
        foreach (mem_bit[a]) mem_bit[a] = -1;
        if (mode != 0) begin
            for (int n = 0; n < 30; n++) mem_bit[$urandom_range(0, (1 << ADDR_W) - 1)] = $urandom_range(0, ROW_W - 1);
            for (int k = 0; k < NH; k++)
                if (mode == 1 || $urandom_range(0, 7) != 0) mem_bit[ref_addr(key, k)] = $urandom_range(0, ROW_W - 1);
                else mem_bit[ref_addr(key, k)] = -1;
            if (clr >= 0) mem_bit[ref_addr(key, clr)] = -1;
        end
    endtask

    task automatic query_a(input logic [DATA_W-1:0] key, input int rdy_wait, input bit poke,
                           output int lat, output logic hit);
        logic v0;
        q_a.delete();
        @(negedge clk);
        chk("idle_query_ready", ifa.query_ready, 1);
        ifa.query_valid = 1'b1;
        ifa.query_data  = key;
        @(negedge clk);
        ifa.query_valid = 1'b0;
        lat = 1;
        while (ifa.result_valid !== 1'b1 && lat < 64) begin
            @(negedge clk);
            lat++;
        end
        hit = ifa.result_hit;
        if (ifa.result_valid !== 1'b1) begin
            chk("result_timeout", 0, 1);
            return;
        end
        for (int w = 0; w < rdy_wait; w++) begin
            v0 = ifa.result_valid;
            chk("hold_valid", v0, 1);
            chk("hold_hit", ifa.result_hit, hit);
            chk("hold_query_ready", ifa.query_ready, 0);
            ifa.query_valid = poke && (w == 1);
            ifa.query_data  = ~key;
            @(negedge clk);
        end
        ifa.query_valid  = 1'b0;
        ifa.result_ready = 1'b1;
        @(negedge clk);
        ifa.result_ready = 1'b0;
        chk("back_to_idle", ifa.busy, 0);
        chk("no_result_in_idle", ifa.result_valid, 0);
        if (poke) begin
            @(negedge clk);
            chk("poke_not_accepted", ifa.busy, 0);
        end
    endtask

    // Compares one completed query with the reference: hit, latency, issue count and address order
    task automatic check_query(input string tag, input logic [DATA_W-1:0] key, input int lat,
                               input logic hit, input int rl, input logic [ADDR_W-1:0] q[$]);
        int   m;
        int   full;
        int   pulses;
        m = -1;
        for (int k = 0; k < NH; k++) if (m < 0 && mem_bit[ref_addr(key, k)] < 0) m = k;
        full   = 2 + NH + rl;
        pulses = NH;
        chk({tag, "_hit"}, hit, (m < 0));
`ifdef BLOOM_QUERY_EARLY_EXIT_EN
        if (m >= 0 && m + rl < NH) begin
            pulses = m + rl + 1;
            chk({tag, "_early_lat"}, (lat < full) && (lat > 2 + m + rl), 1);
        end else begin
            chk({tag, "_lat"}, lat, full);
        end
`else
        chk({tag, "_lat"}, lat, full);
`endif
        chk({tag, "_pulses"}, q.size(), pulses);
        for (int i = 0; i < q.size() && i < NH; i++) chk({tag, "_addra"}, q[i], ref_addr(key, i));
    endtask

    typedef struct {
        logic [DATA_W-1:0] key;
        int                mode;
        int                clr;
        int                rdy;
        bit                poke;
        logic              exp_hit;
    } vec_t;

    initial begin
        vec_t vecs[7];
        logic [DATA_W-1:0] kk;
        logic [DATA_W-1:0] rk;
        int   lat;
        logic hit;

        kk = 72'hA5_0F1E_2D3C_4B5A_6978;
        vecs[0] = '{72'h01_2345_6789_ABCD_EF01, 0, -1, 0, 1'b0, 1'b0};
        vecs[1] = '{kk, 1, -1, 0, 1'b0, 1'b1};
        vecs[2] = '{kk, 1,  3, 0, 1'b0, 1'b0};
        vecs[3] = '{kk, 1,  0, 1, 1'b0, 1'b0};
        vecs[4] = '{kk, 1,  6, 0, 1'b0, 1'b0};
        vecs[5] = '{72'hFF_FFFF_FFFF_FFFF_FFFF, 1, -1, 5, 1'b1, 1'b1};
        vecs[6] = '{72'h0, 1, -1, 2, 1'b0, 1'b1};

        ifa.query_valid = 1'b0; ifa.query_data = '0; ifa.result_ready = 1'b0;
        ifb.query_valid = 1'b0; ifb.query_data = '0; ifb.result_ready = 1'b0;
        foreach (mem_bit[a]) mem_bit[a] = -1;
        rst = 1'b1;
        repeat (3) @(negedge clk);

        chk("rst_a_query_ready", ifa.query_ready, 0);
        chk("rst_a_result_valid", ifa.result_valid, 0);
        chk("rst_a_result_hit", ifa.result_hit, 0);
        chk("rst_a_busy", ifa.busy, 0);
        chk("rst_a_ena", ifa.ena, 0);
        chk("rst_a_addra", ifa.addra, 0);
        chk("rst_a_wea", ifa.wea, 0);
        chk("rst_b_query_ready", ifb.query_ready, 0);
        chk("rst_b_busy", ifb.busy, 0);
        chk("rst_b_ena", ifb.ena, 0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            preload(vecs[i].key, vecs[i].mode, vecs[i].clr);
            query_a(vecs[i].key, vecs[i].rdy, vecs[i].poke, lat, hit);
            chk($sformatf("vec%0d_hit", i), hit, vecs[i].exp_hit);
            check_query($sformatf("vec%0d", i), vecs[i].key, lat, hit, RL_A, q_a);
        end

        // reset while read k=4 is being issued
        preload(kk, 1, -1);
        @(negedge clk);
        ifa.query_valid = 1'b1;
        ifa.query_data  = kk;
        @(negedge clk);
        ifa.query_valid = 1'b0;
        repeat (5) @(negedge clk);
        chk("midrst_issuing", ifa.ena, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_ena", ifa.ena, 0);
        chk("midrst_result_valid", ifa.result_valid, 0);
        chk("midrst_busy", ifa.busy, 0);
        chk("midrst_query_ready", ifa.query_ready, 0);
        rst = 1'b0;
        query_a(kk, 0, 1'b0, lat, hit);
        chk("postrst_hit", hit, 1);
        check_query("postrst", kk, lat, hit, RL_A, q_a);

        // READ_LATENCY=3 instance, all rows of kk set
        preload(kk, 1, -1);
        q_b.delete();
        @(negedge clk);
        chk("rl3_query_ready", ifb.query_ready, 1);
        ifb.query_valid = 1'b1;
        ifb.query_data  = kk;
        @(negedge clk);
        ifb.query_valid = 1'b0;
        lat = 1;
        while (ifb.result_valid !== 1'b1 && lat < 64) begin
            @(negedge clk);
            lat++;
        end
        chk("rl3_lat12", lat, 12);
        chk("rl3_hit1", ifb.result_hit, 1);
        check_query("rl3", kk, lat, ifb.result_hit, RL_B, q_b);
        ifb.result_ready = 1'b1;
        @(negedge clk);
        ifb.result_ready = 1'b0;
        chk("rl3_idle", ifb.busy, 0);

        for (int it = 0; it < 40; it++) begin
            rk = {8'($urandom), $urandom, $urandom};
            preload(rk, 2, -1);
            query_a(rk, $urandom_range(0, 2), 1'b0, lat, hit);
            check_query("rand", rk, lat, hit, RL_A, q_a);
        end

        chk("wea_always_zero", wea_bad, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
